dma_copy: RTL

DMA_COPY -- requirements
Module: dma_copy

---
 rtl/dma_copy_if.sv | 42 ++++
 rtl/dma_copy.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_copy_if.sv
`default_nettype none
// ============================================================================
//  Module   : dma_copy_if
//  Purpose  : Bundles the dma_copy control and lane-parallel DRAM signals.
//             The slave modport is the copy engine's view and the master
//             modport is the requester/DRAM view.
//  Signals  : en/src/dst/size       start request and transfer descriptor
//             busy/done/error       status back to the requester
//             dram_en/we/addr/data_out  per-lane DRAM request
//             dram_data_in/valid    per-lane DRAM read return
//  Revision : 1.0 - initial release
// ============================================================================
interface dma_copy_if #(
    parameter int LANES  = 8,
    parameter int ADDR_W = 64,
    parameter int SIZE_W = 15
);
    logic                           en;
    logic [ADDR_W-1:0]              src;
    logic [ADDR_W-1:0]              dst;
    logic [SIZE_W-1:0]              size;
    logic                           busy;
    logic                           done;
    logic                           error;
    logic [LANES-1:0]               dram_en;
    logic                           dram_we;
    logic [LANES-1:0][ADDR_W-1:0]   dram_addr;
    logic [LANES-1:0][7:0]          dram_data_out;
    logic [LANES-1:0][7:0]          dram_data_in;
    logic [LANES-1:0]               dram_valid;

    modport slave (
        input  en, src, dst, size, dram_data_in, dram_valid,
        output busy, done, error, dram_en, dram_we, dram_addr, dram_data_out
    );

    modport master (
        output en, src, dst, size, dram_data_in, dram_valid,
        input  busy, done, error, dram_en, dram_we, dram_addr, dram_data_out
    );
endinterface
`default_nettype wire

// File: rtl/dma_copy.sv
`default_nettype none
// ============================================================================
//  Module   : dma_copy
//  Purpose  : Byte-lane DMA copy engine. Moves size bytes from src to dst in
//             beats of up to LANES bytes: one read issue, wait for every
//             active lane to return data (with timeout), one write issue,
//             then a fixed write-settle delay.
//  Ports    : clk    - clock, rising edge
//             reset  - synchronous active-high reset
//             bus    - dma_copy_if.slave (request, status, DRAM lanes)
//  Revision : 1.0 - initial release
// ============================================================================
module dma_copy #(
    parameter int LANES      = 8,
    parameter int ADDR_W     = 64,
    parameter int SIZE_W     = 15,
    parameter int WR_LAT     = 20,
    parameter int RD_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    dma_copy_if.slave    bus
);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_WR_ISSUE = 3'd3;
    localparam logic [2:0] c_ST_WR_WAIT  = 3'd4;
    localparam logic [2:0] c_ST_DONE     = 3'd5;

    localparam logic [SIZE_W:0] c_LANES   = (SIZE_W+1)'(LANES);
    localparam logic [7:0]      c_RD_LAST = 8'(RD_TIMEOUT - 1);
    localparam logic [7:0]      c_WR_LAST = 8'(WR_LAT - 1);

    logic [2:0]                    r_state;
    logic [ADDR_W-1:0]             r_src;
    logic [ADDR_W-1:0]             r_dst;
    logic [SIZE_W-1:0]             r_size;
    logic [SIZE_W:0]               r_copied;
    logic [LANES-1:0][7:0]         r_data;
    logic [LANES-1:0]              r_got;
    logic [7:0]                    r_rd_cnt;
    logic [7:0]                    r_wr_cnt;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_error;
    logic [LANES-1:0]              r_dram_en;
    logic                          r_dram_we;
    logic [LANES-1:0][ADDR_W-1:0]  r_dram_addr;
    logic [LANES-1:0][7:0]         r_dram_data_out;

    logic [SIZE_W:0]               w_remain;
    logic [SIZE_W:0]               w_beat;
    logic [LANES-1:0]              w_mask;
    logic [SIZE_W:0]               w_copied_nx;
    logic [SIZE_W:0]               w_remain_nx;
    logic [LANES-1:0]              w_got_nx;
    logic [LANES-1:0][7:0]         w_data_nx;

    // Lane i is active when fewer than i+1 bytes remain uncopied is false,
    // i.e. lanes 0..min(LANES,remain)-1 are set.
    function automatic logic [LANES-1:0] f_mask(input logic [SIZE_W:0] remain);
        logic [LANES-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[i] = ((SIZE_W+1)'(i) < remain);
        end
        return m;
    endfunction

    // Per-lane byte addresses base + offset + i, wrapping at 2^ADDR_W.
    function automatic logic [LANES-1:0][ADDR_W-1:0] f_addrs(
        input logic [ADDR_W-1:0] base,
        input logic [SIZE_W:0]   offset
    );
        logic [LANES-1:0][ADDR_W-1:0] a;
        for (int i = 0; i < LANES; i++) begin
            a[i] = base + ADDR_W'(offset) + ADDR_W'(i);
        end
        return a;
    endfunction

    assign w_remain    = {1'b0, r_size} - r_copied;
    assign w_beat      = (w_remain > c_LANES) ? c_LANES : w_remain;
    assign w_mask      = f_mask(w_remain);
    assign w_copied_nx = r_copied + w_beat;
    assign w_remain_nx = {1'b0, r_size} - w_copied_nx;
    assign w_got_nx    = r_got | (bus.dram_valid & w_mask);

    // Read data including bytes arriving this cycle, so a beat whose last
    // lane returns now can be written without an extra cycle.
    always_comb begin
        w_data_nx = r_data;
        for (int i = 0; i < LANES; i++) begin
            if (bus.dram_valid[i] && w_mask[i]) begin
                w_data_nx[i] = bus.dram_data_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_ST_IDLE;
            r_src           <= '0;
            r_dst           <= '0;
            r_size          <= '0;
            r_copied        <= '0;
            r_data          <= '0;
            r_got           <= '0;
            r_rd_cnt        <= '0;
            r_wr_cnt        <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_dram_en       <= '0;
            r_dram_we       <= 1'b0;
            r_dram_addr     <= '0;
            r_dram_data_out <= '0;
        end else begin
            // Strobes and the done pulse are single-cycle unless re-armed below.
            r_done    <= 1'b0;
            r_dram_en <= '0;
            r_dram_we <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (bus.en) begin
                        r_src    <= bus.src;
                        r_dst    <= bus.dst;
                        r_size   <= bus.size;
                        r_copied <= '0;
                        r_error  <= 1'b0;
                        r_data   <= '0;
                        r_busy   <= 1'b1;
                        if (bus.size == '0) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= c_ST_RD_ISSUE;
                            r_dram_en   <= f_mask({1'b0, bus.size});
                            r_dram_addr <= f_addrs(bus.src, '0);
                        end
                    end
                end

                c_ST_RD_ISSUE: begin
                    r_state  <= c_ST_RD_WAIT;
                    r_got    <= '0;
                    r_rd_cnt <= '0;
                end

                c_ST_RD_WAIT: begin
                    r_data   <= w_data_nx;
                    r_got    <= w_got_nx;
                    r_rd_cnt <= r_rd_cnt + 8'd1;
                    if (w_got_nx == w_mask) begin
                        r_state         <= c_ST_WR_ISSUE;
                        r_dram_en       <= w_mask;
                        r_dram_we       <= 1'b1;
                        r_dram_addr     <= f_addrs(r_dst, r_copied);
                        r_dram_data_out <= w_data_nx;
                    end else if (r_rd_cnt == c_RD_LAST) begin
                        // Timed-out beat is abandoned without being written.
                        r_state <= c_ST_DONE;
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                    end
                end

                c_ST_WR_ISSUE: begin
                    r_state  <= c_ST_WR_WAIT;
                    r_wr_cnt <= '0;
                end

                c_ST_WR_WAIT: begin
                    r_wr_cnt <= r_wr_cnt + 8'd1;
                    if (r_wr_cnt == c_WR_LAST) begin
                        r_copied <= w_copied_nx;
                        if (w_remain_nx == '0) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= c_ST_RD_ISSUE;
                            r_dram_en   <= f_mask(w_remain_nx);
                            r_dram_addr <= f_addrs(r_src, w_copied_nx);
                        end
                    end
                end

                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.error         = r_error;
    assign bus.dram_en       = r_dram_en;
    assign bus.dram_we       = r_dram_we;
    assign bus.dram_addr     = r_dram_addr;
    assign bus.dram_data_out = r_dram_data_out;

endmodule
`default_nettype wire
